haraka_s_sponge_ctrl: RTL and testbench

Sponge controller for Haraka-S: absorbs a byte-granular message in 256-bit rate blocks, applies Haraka-S padding, drives the 512-bit Haraka permutation core through a start/done handshake, and squeezes a programmable number of 256-bit output blocks. It sits between the hash front end (message stream in, digest stream out) and the permutation core. It owns the 512-bit sponge state.

---
 rtl/haraka_s_pkg.sv | 33 +++
 rtl/haraka_s_pad.sv | 41 ++++
 rtl/haraka_s_sponge_ctrl.sv | 168 ++++++++++++++++
 tb/tb_haraka_s_sponge_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/haraka_s_pkg.sv
`default_nettype none
// ============================================================================
// Module  : haraka_s_pkg
// Purpose : Shared constants, FSM encoding and byte-lane helper for the
//           Haraka-S sponge controller and its padding block.
// Rev     : 1.0  initial release
// ============================================================================
package haraka_s_pkg;

  localparam int RATE_BITS  = 256;
  localparam int STATE_BITS = 512;
  localparam int RATE_BYTES = RATE_BITS / 8;

  localparam logic [7:0] PAD_FIRST = 8'h1F;
  localparam logic [7:0] PAD_LAST  = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ABSORB   = 3'd1,
    ST_PERM_ABS = 3'd2,
    ST_PAD      = 3'd3,
    ST_PERM_PAD = 3'd4,
    ST_OUT      = 3'd5,
    ST_PERM_SQ  = 3'd6
  } sponge_state_e;

  // Byte 0 of a rate block sits in the most significant lane.
  function automatic int byte_msb(input int idx);
    return RATE_BITS - 1 - 8 * idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/haraka_s_pad.sv
`default_nettype none
// ============================================================================
// Module  : haraka_s_pad
// Purpose : Combinational mask-and-pad of the final rate block.
//           Bytes at index >= msg_bytes are cleared, PAD_FIRST is placed at
//           byte msg_bytes and PAD_LAST is XORed into byte 31.  With pad_only
//           set the message is ignored and the pad-only block is produced.
// Ports   : msg_data  [255:0] in  message bytes, byte i at [255-8i -: 8]
//           msg_bytes [5:0]   in  valid byte count (meaningful for 0..31)
//           pad_only          in  produce the pad-only block
//           pad_block [255:0] out padded rate block
// Rev     : 1.0  initial release
// ============================================================================
module haraka_s_pad
  import haraka_s_pkg::*;
(
  input  logic [RATE_BITS-1:0] msg_data,
  input  logic [5:0]           msg_bytes,
  input  logic                 pad_only,
  output logic [RATE_BITS-1:0] pad_block
);

  logic [5:0] w_pos;

  always_comb begin
    w_pos     = pad_only ? 6'd0 : msg_bytes;
    pad_block = '0;
    for (int i = 0; i < RATE_BYTES; i++) begin
      if (6'(i) < w_pos) begin
        pad_block[byte_msb(i) -: 8] = msg_data[byte_msb(i) -: 8];
      end
      if (6'(i) == w_pos) begin
        pad_block[byte_msb(i) -: 8] = PAD_FIRST;
      end
    end
    // Byte 31 is the last lane; for a 31-byte message it combines to 0x9F.
    pad_block[7:0] = pad_block[7:0] ^ PAD_LAST;
  end

endmodule
`default_nettype wire

// File: rtl/haraka_s_sponge_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : haraka_s_sponge_ctrl
// Purpose : Haraka-S sponge controller.  Absorbs a byte-granular message in
//           256-bit rate blocks, pads the tail, sequences the 512-bit
//           permutation core over a start/done handshake and squeezes a
//           programmable number of 256-bit digest blocks.
// Ports   : clk, rst_n                  clock, synchronous active-low reset
//           msg_valid/ready/data/bytes/last, sq_blocks   message stream in
//           perm_start/state, perm_done/result           permutation core
//           out_valid/ready/data/last                    digest stream out
// Config  : HARAKA_S_CTRL_ZEROIZE_EN - when defined, perm_state reads zero
//           unless a permutation is in flight and out_data reads zero while
//           out_valid is low.
// Rev     : 1.0  initial release
// ============================================================================
module haraka_s_sponge_ctrl
  import haraka_s_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  msg_valid,
  output logic                  msg_ready,
  input  logic [RATE_BITS-1:0]  msg_data,
  input  logic [5:0]            msg_bytes,
  input  logic                  msg_last,
  input  logic [3:0]            sq_blocks,
  output logic                  perm_start,
  output logic [STATE_BITS-1:0] perm_state,
  input  logic                  perm_done,
  input  logic [STATE_BITS-1:0] perm_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RATE_BITS-1:0]  out_data,
  output logic                  out_last
);

  sponge_state_e         r_fsm, w_fsm_nxt;
  logic [STATE_BITS-1:0] r_state, w_state_nxt;
  logic [3:0]            r_blocks, w_blocks_nxt;
  logic                  r_pad_pend, w_pad_pend_nxt;
  logic                  r_start, w_start_nxt;

  logic                  w_full_last;
  logic                  w_pad_only;
  logic [RATE_BITS-1:0]  w_pad_blk;
  logic [RATE_BITS-1:0]  w_rate;

  assign w_rate      = r_state[STATE_BITS-1 -: RATE_BITS];
  assign w_pad_only  = (r_fsm == ST_PAD);
  // Counts above 32 behave as a full block.
  assign w_full_last = (msg_bytes >= 6'd32);

  haraka_s_pad u_pad (
    .msg_data  (msg_data),
    .msg_bytes (msg_bytes),
    .pad_only  (w_pad_only),
    .pad_block (w_pad_blk)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm      <= ST_IDLE;
      r_state    <= '0;
      r_blocks   <= 4'd0;
      r_pad_pend <= 1'b0;
      r_start    <= 1'b0;
    end else begin
      r_fsm      <= w_fsm_nxt;
      r_state    <= w_state_nxt;
      r_blocks   <= w_blocks_nxt;
      r_pad_pend <= w_pad_pend_nxt;
      r_start    <= w_start_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt      = r_fsm;
    w_state_nxt    = r_state;
    w_blocks_nxt   = r_blocks;
    w_pad_pend_nxt = r_pad_pend;
    w_start_nxt    = 1'b0;
    msg_ready      = 1'b0;
    out_valid      = 1'b0;
    out_last       = 1'b0;

    case (r_fsm)
      ST_IDLE, ST_ABSORB: begin
        msg_ready = 1'b1;
        if (msg_valid) begin
          // Squeeze count belongs to the message, so take it from beat one.
          if (r_fsm == ST_IDLE) begin
            w_blocks_nxt = (sq_blocks == 4'd0) ? 4'd1 : sq_blocks;
          end
          w_start_nxt = 1'b1;
          if (msg_last && !w_full_last) begin
            w_state_nxt[STATE_BITS-1 -: RATE_BITS] = w_rate ^ w_pad_blk;
            w_pad_pend_nxt = 1'b0;
            w_fsm_nxt      = ST_PERM_PAD;
          end else begin
            // A full final block still needs a separate pad-only block.
            w_state_nxt[STATE_BITS-1 -: RATE_BITS] = w_rate ^ msg_data;
            w_pad_pend_nxt = msg_last;
            w_fsm_nxt      = ST_PERM_ABS;
          end
        end
      end

      ST_PERM_ABS: begin
        if (perm_done) begin
          w_state_nxt = perm_result;
          w_fsm_nxt   = r_pad_pend ? ST_PAD : ST_ABSORB;
        end
      end

      ST_PAD: begin
        w_state_nxt[STATE_BITS-1 -: RATE_BITS] = w_rate ^ w_pad_blk;
        w_pad_pend_nxt = 1'b0;
        w_start_nxt    = 1'b1;
        w_fsm_nxt      = ST_PERM_PAD;
      end

      ST_PERM_PAD, ST_PERM_SQ: begin
        if (perm_done) begin
          w_state_nxt = perm_result;
          w_fsm_nxt   = ST_OUT;
        end
      end

      ST_OUT: begin
        out_valid = 1'b1;
        out_last  = (r_blocks == 4'd1);
        if (out_ready) begin
          if (r_blocks > 4'd1) begin
            w_blocks_nxt = r_blocks - 4'd1;
            w_start_nxt  = 1'b1;
            w_fsm_nxt    = ST_PERM_SQ;
          end else begin
            // Final block consumed: nothing of this message survives.
            w_state_nxt  = '0;
            w_blocks_nxt = 4'd0;
            w_fsm_nxt    = ST_IDLE;
          end
        end
      end

      default: begin
        w_fsm_nxt = ST_IDLE;
      end
    endcase
  end

  assign perm_start = r_start;

`ifdef HARAKA_S_CTRL_ZEROIZE_EN
  logic w_perm_busy;
  // perm_start is only ever high inside a PERM_* state.
  assign w_perm_busy = (r_fsm == ST_PERM_ABS) || (r_fsm == ST_PERM_PAD) ||
                       (r_fsm == ST_PERM_SQ);
  assign perm_state  = w_perm_busy ? r_state : '0;
  assign out_data    = out_valid ? w_rate : '0;
`else
  assign perm_state  = r_state;
  assign out_data    = w_rate;
`endif

endmodule
`default_nettype wire

// File: tb/tb_haraka_s_sponge_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_haraka_s_sponge_ctrl
// Purpose : Self-checking bench for haraka_s_sponge_ctrl.  The permutation
//           core is modelled as a left rotate by 8 bits with a latency of 3
//           cycles.  Expected permutation inputs and digest blocks are queued
//           when stimulus is issued and a monitor compares them against the
//           DUT whenever perm_start or out_valid is seen.
// Rev     : 1.0  initial release
// ============================================================================
module tb_haraka_s_sponge_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         msg_valid = 1'b0;
  logic         msg_ready;
  logic [255:0] msg_data = '0;
  logic [5:0]   msg_bytes = 6'd0;
  logic         msg_last = 1'b0;
  logic [3:0]   sq_blocks = 4'd0;
  logic         perm_start;
  logic [511:0] perm_state;
  logic         perm_done;
  logic [511:0] perm_result;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [255:0] out_data;
  logic         out_last;

  always #5 clk = ~clk;

  haraka_s_sponge_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .msg_valid   (msg_valid),
    .msg_ready   (msg_ready),
    .msg_data    (msg_data),
    .msg_bytes   (msg_bytes),
    .msg_last    (msg_last),
    .sq_blocks   (sq_blocks),
    .perm_start  (perm_start),
    .perm_state  (perm_state),
    .perm_done   (perm_done),
    .perm_result (perm_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last)
  );

  function automatic logic [511:0] rotl8(input logic [511:0] s);
    return {s[503:0], s[511:504]};
  endfunction

  // Permutation core model: keeps running through DUT reset on purpose.
  logic [511:0] m_res = '0;
  int           m_cnt = 0;
  always @(posedge clk) begin
    if (perm_start) begin
      m_res <= rotl8(perm_state);
      m_cnt <= 3;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end
  end
  assign perm_done   = (m_cnt == 1);
  assign perm_result = m_res;

  typedef struct packed {
    logic [255:0] data;
    logic         last;
  } out_t;

  logic [511:0] perm_q[$];
  out_t         out_q[$];
  logic [511:0] exp_st = '0;
  int           total = 0;
  int           bad = 0;
  bit           ready_mode = 1'b0;
  int           rcyc = 0;

  localparam logic [255:0] PADONLY = {8'h1F, 240'h0, 8'h80};

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference padding, built lane by lane from a byte array.
  function automatic logic [255:0] tb_pad(input logic [255:0] d, input int n);
    logic [7:0]   b [32];
    logic [255:0] r;
    for (int i = 0; i < 32; i++) b[i] = (i < n) ? d[255-8*i -: 8] : 8'h00;
    b[n]  = b[n] ^ 8'h1F;
    b[31] = b[31] ^ 8'h80;
    for (int i = 0; i < 32; i++) r[255-8*i -: 8] = b[i];
    return r;
  endfunction

  task automatic ref_beat(input logic [255:0] d, input int n, input bit last);
    if (!last || n >= 32) begin
      exp_st[511:256] = exp_st[511:256] ^ d;
      perm_q.push_back(exp_st);
      exp_st = rotl8(exp_st);
      if (last) begin
        exp_st[511:256] = exp_st[511:256] ^ PADONLY;
        perm_q.push_back(exp_st);
        exp_st = rotl8(exp_st);
      end
    end else begin
      exp_st[511:256] = exp_st[511:256] ^ tb_pad(d, n);
      perm_q.push_back(exp_st);
      exp_st = rotl8(exp_st);
    end
  endtask

  task automatic ref_squeeze(input int nb);
    out_t e;
    for (int k = 0; k < nb; k++) begin
      e.data = exp_st[511:256];
      e.last = (k == nb - 1);
      out_q.push_back(e);
      if (k < nb - 1) begin
        perm_q.push_back(exp_st);
        exp_st = rotl8(exp_st);
      end
    end
    exp_st = '0;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send_beat(input logic [255:0] d, input logic [5:0] n,
                           input logic last, input logic [3:0] sq);
    int  waited;
    bit  got;
    waited    = 0;
    got       = 1'b0;
    msg_valid = 1'b1;
    msg_data  = d;
    msg_bytes = n;
    msg_last  = last;
    sq_blocks = sq;
    while (!got && waited < 500) begin
      @(negedge clk);
      if (msg_ready) got = 1'b1;
      else waited++;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL msg_accept_timeout: got msg_ready=0 required msg_ready=1");
    end
    @(posedge clk);
    #1;
    msg_valid = 1'b0;
    msg_last  = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((perm_q.size() != 0 || out_q.size() != 0) && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("perm_q_drained", 512'(perm_q.size()), 512'd0);
    chk("out_q_drained", 512'(out_q.size()), 512'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every permutation launch and every presented block.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (perm_start) begin
          if (perm_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL perm_start_unexpected: got perm_start=1 required 0");
          end else begin
            chk("perm_state", perm_state, perm_q.pop_front());
          end
        end
        if (out_valid) begin
          if (out_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL out_valid_unexpected: got out_valid=1 required 0");
          end else begin
            chk("out_data", 512'(out_data), 512'(out_q[0].data));
            chk("out_last", 512'(out_last), 512'(out_q[0].last));
            if (out_ready) void'(out_q.pop_front());
          end
        end
      end
    end
  end

  // Consumer: always ready, or ready one cycle in three.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rcyc++;
      out_ready = ready_mode ? (rcyc % 3 == 2) : 1'b1;
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got no completion required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] d1, d2, daa;
    out_t         e;
    int           lat;

    for (int i = 0; i < 32; i++) d1[255-8*i -: 8] = 8'(i);
    for (int i = 0; i < 32; i++) d2[255-8*i -: 8] = 8'(8'hC0 + i);
    daa = {{31{8'hAA}}, 8'h00};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_msg_ready", 512'(msg_ready), 512'd1);
    chk("rst_out_valid", 512'(out_valid), 512'd0);
    chk("rst_out_last", 512'(out_last), 512'd0);
    chk("rst_perm_start", 512'(perm_start), 512'd0);
    chk("rst_perm_state", perm_state, 512'd0);
    chk("rst_out_data", 512'(out_data), 512'd0);

    // Empty message: one permutation, latency 2 + 3
    perm_q.push_back({8'h1F, 240'h0, 8'h80, 256'h0});
    e.data = {240'h0, 8'h80, 8'h00};
    e.last = 1'b1;
    out_q.push_back(e);
    send_beat('0, 6'd0, 1'b1, 4'd1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 50);
    chk("empty_latency", 512'(lat), 512'd5);
    drain();

    // 31 bytes of 0xAA
    perm_q.push_back({{31{8'hAA}}, 8'h9F, 256'h0});
    e.data = {{30{8'hAA}}, 8'h9F, 8'h00};
    e.last = 1'b1;
    out_q.push_back(e);
    send_beat(daa, 6'd31, 1'b1, 4'd1);
    drain();

    // Full 32-byte last beat: absorb, then pad-only block
    ref_beat(d1, 32, 1'b1);
    ref_squeeze(1);
    send_beat(d1, 6'd32, 1'b1, 4'd1);
    drain();

    // Two-beat message, three squeezed blocks, consumer stalls
    ready_mode = 1'b1;
    ref_beat(d1, 32, 1'b0);
    ref_beat(d2, 5, 1'b1);
    ref_squeeze(3);
    send_beat(d1, 6'd3, 1'b0, 4'd3);
    send_beat(d2, 6'd5, 1'b1, 4'd9);
    drain();
    ready_mode = 1'b0;

    // Reset while a permutation is in flight
    ref_beat(d1, 32, 1'b0);
    exp_st = '0;
    send_beat(d1, 6'd32, 1'b0, 4'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst2_msg_ready", 512'(msg_ready), 512'd1);
    chk("rst2_out_valid", 512'(out_valid), 512'd0);
    chk("rst2_perm_start", 512'(perm_start), 512'd0);
    chk("rst2_perm_state", perm_state, 512'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("stale_done_msg_ready", 512'(msg_ready), 512'd1);
    chk("stale_done_perm_state", perm_state, 512'd0);
    chk("stale_done_out_valid", 512'(out_valid), 512'd0);
    perm_q.push_back({{31{8'hAA}}, 8'h9F, 256'h0});
    e.data = {{30{8'hAA}}, 8'h9F, 8'h00};
    e.last = 1'b1;
    out_q.push_back(e);
    send_beat(daa, 6'd31, 1'b1, 4'd1);
    drain();

    // Back-to-back messages, sq_blocks=0, oversized byte count on the second
    ref_beat(d2, 3, 1'b1);
    ref_squeeze(1);
    ref_beat(d1, 45, 1'b1);
    ref_squeeze(1);
    send_beat(d2, 6'd3, 1'b1, 4'd0);
    send_beat(d1, 6'd45, 1'b1, 4'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
